// File: rtl/seg7_scan_if.sv
// Display-side bundle for the 7-segment scan multiplexer.
// The master drives digit data; the slave drives the pins.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    lz_blank_en;
  logic [6:0]              segments;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_done;

  modport master (
    output digits_in, dp_in, load, lz_blank_en,
    input  segments, dp_out, digit_en, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, lz_blank_en,
    output segments, dp_out, digit_en, frame_done
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with dead-time blanking,
// leading-zero suppression and frame-aligned display updates.
module seg7_scan_mux #(
  parameter int          NUM_DIGITS   = 4,
  parameter logic [23:0] SCAN_DIV     = 24'd10_000,
  parameter logic [23:0] BLANK_CYCLES = 24'd100
) (
  input  logic        clk,
  input  logic        reset,
  seg7_scan_if.slave  io
);
  localparam int W = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

  logic [23:0]           cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [W-1:0]          disp_q, disp_d;
  logic [W-1:0]          pend_q, pend_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
  logic                  pv_q, pv_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fd_q, fd_d;

  logic                  slot_end;
  logic                  boundary;
  logic                  blank;
  logic                  show;
  logic                  supp;
  logic                  dpb;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] zhi;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'h3F;
      4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;
      4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;
      4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;
      4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h6F;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;
      4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;
      default: dec = 7'h71;
    endcase
  endfunction

  assign slot_end = (cnt_q == SCAN_DIV - 24'd1);
  assign boundary = slot_end && (idx_q == LAST);
  assign blank    = (cnt_q < BLANK_CYCLES);

  // zhi[i]: nibble i and every nibble above it are zero
  always_comb begin : zero_scan
    logic z;
    z   = 1'b1;
    zhi = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z      = z && (disp_q[4*i +: 4] == 4'h0);
      zhi[i] = z;
    end
  end

  always_comb begin
    nib  = 4'h0;
    dpb  = 1'b0;
    supp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        nib  = disp_q[4*i +: 4];
        dpb  = ddp_q[i];
        supp = (i > 0) && zhi[i];
      end
    end
  end

  assign show = !blank && !(io.lz_blank_en && supp);

  always_comb begin
    cnt_d  = slot_end ? 24'd0 : cnt_q + 24'd1;
    idx_d  = idx_q;
    disp_d = disp_q;
    ddp_d  = ddp_q;
    pend_d = pend_q;
    pdp_d  = pdp_q;
    pv_d   = pv_q;
    en_d   = '0;
    if (slot_end) begin
      idx_d = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
    end
    if (boundary) begin
      pv_d = 1'b0;
      if (io.load) begin
        disp_d = io.digits_in;
        ddp_d  = io.dp_in;
      end else if (pv_q) begin
        disp_d = pend_q;
        ddp_d  = pdp_q;
      end
    end else if (io.load) begin
      pend_d = io.digits_in;
      pdp_d  = io.dp_in;
      pv_d   = 1'b1;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) en_d[i] = show;
    end
    seg_d = show ? dec(nib) : 7'h00;
    dpo_d = show && dpb;
    fd_d  = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      ddp_q  <= '0;
      pend_q <= '0;
      pdp_q  <= '0;
      pv_q   <= 1'b0;
      seg_q  <= '0;
      dpo_q  <= 1'b0;
      en_q   <= '0;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      ddp_q  <= ddp_d;
      pend_q <= pend_d;
      pdp_q  <= pdp_d;
      pv_q   <= pv_d;
      seg_q  <= seg_d;
      dpo_q  <= dpo_d;
      en_q   <= en_d;
      fd_q   <= fd_d;
    end
  end

  assign io.segments   = seg_q;
  assign io.dp_out     = dpo_q;
  assign io.digit_en   = en_q;
  assign io.frame_done = fd_q;
endmodule
